reg_scoreboard: RTL and testbench

Issue controller and write-port arbiter for the decode-stage register file. It tracks every register with an outstanding write and holds the decode-stage instruction on RAW and WAW hazards. It also shares the register file's single write port between the fixed-latency ALU writeback and a variable-latency long unit (load/mul-div). Its `rf_*` outputs drive the register file's RegWrite/rd/Writedata inputs directly.

---
 rtl/rv_pkg.sv | 21 ++
 rtl/reg_scoreboard_if.sv | 45 ++++
 rtl/wb_arbiter.sv | 59 +++++
 rtl/reg_scoreboard.sv | 103 ++++++++++
 tb/tb_reg_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared register-file definitions for the decode-stage issue logic.
// Provides the architectural widths and the writeback request bundle
// (valid, rd, data) carried by both the ALU and long-unit writeback ports.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int NREG  = 32;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  // x0 is hard-wired to zero: it is never tracked, never stalls, never written.
  function automatic logic reg_nz(input logic [REG_W-1:0] r);
    return r != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/register-file bundle for reg_scoreboard.
//   master : decode stage, execute-ready, both writeback sources (drive);
//            issue/stall, wbb_ready, rf_* (observe)
//   slave  : reg_scoreboard itself
interface reg_scoreboard_if;

  logic                     id_valid;
  logic [rv_pkg::REG_W-1:0] id_rs1;
  logic [rv_pkg::REG_W-1:0] id_rs2;
  logic                     id_use_rs1;
  logic                     id_use_rs2;
  logic [rv_pkg::REG_W-1:0] id_rd;
  logic                     id_wr;
  logic                     id_long;
  logic                     ex_ready;
  logic                     issue;
  logic                     stall;

  logic                     wba_valid;
  logic [rv_pkg::REG_W-1:0] wba_rd;
  logic [rv_pkg::XLEN-1:0]  wba_data;
  logic                     wbb_valid;
  logic [rv_pkg::REG_W-1:0] wbb_rd;
  logic [rv_pkg::XLEN-1:0]  wbb_data;
  logic                     wbb_ready;

  logic                     rf_we;
  logic [rv_pkg::REG_W-1:0] rf_rd;
  logic [rv_pkg::XLEN-1:0]  rf_wdata;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
           id_long, ex_ready, wba_valid, wba_rd, wba_data, wbb_valid,
           wbb_rd, wbb_data,
    input  issue, stall, wbb_ready, rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
           id_long, ex_ready, wba_valid, wba_rd, wba_data, wbb_valid,
           wbb_rd, wbb_data,
    output issue, stall, wbb_ready, rf_we, rf_rd, rf_wdata
  );

endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter.
// The ALU writeback (port a) cannot be back-pressured and always wins; the
// long unit (port b) is accepted only in cycles without an ALU write. A
// saturating counter of consecutive refused port-b cycles raises thr_o so
// the top can block issue and let ALU bubbles open a slot for port b.
//   clk, clr       : clock, synchronous active-high reset
//   wba_i, wbb_i   : writeback requests (valid, rd, data)
//   wbb_ready_o    : port b accepted this cycle
//   rf_we_o/rd/wdata : register-file write port
//   thr_o          : issue throttle request
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int STARVE_LIM = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  wb_req_t          wba_i,
  input  wb_req_t          wbb_i,
  output logic             wbb_ready_o,
  output logic             rf_we_o,
  output logic [REG_W-1:0] rf_rd_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             thr_o
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);

  logic [SC_W-1:0] starve_q, starve_d;
  wb_req_t         sel;

  always_comb begin
    wbb_ready_o = !wba_i.valid;
    if (wba_i.valid)      sel = wba_i;
    else if (wbb_i.valid) sel = wbb_i;
    else                  sel = '0;
    // A write to x0 is consumed (counts as accepted) but never reaches the file.
    rf_we_o    = sel.valid && reg_nz(sel.rd);
    rf_rd_o    = sel.rd;
    rf_wdata_o = sel.data;
  end

  always_comb begin
    if (!wbb_i.valid || wbb_ready_o)
      starve_d = '0;
    else if (starve_q != SC_W'(STARVE_LIM))
      starve_d = starve_q + SC_W'(1);
    else
      starve_d = starve_q;
  end

  assign thr_o = (starve_q == SC_W'(STARVE_LIM));

  always_ff @(posedge clk) begin
    if (clr) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage issue controller and register-file write-port owner.
// Tracks registers with an outstanding write (busy), holds decode on RAW,
// WAW and long-unit-full hazards, counts long ops in flight, and drives the
// register-file write port through wb_arbiter.
//   clk, clr   : clock, synchronous active-high reset
//   bus        : decode / writeback / register-file bundle (slave side)
//   busy_o     : scoreboard bits, for observation
//   long_cnt_o : long-latency ops in flight, for observation
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int LONG_MAX   = 4,
  parameter int STARVE_LIM = 6
) (
  input  logic                         clk,
  input  logic                         clr,
  reg_scoreboard_if.slave              bus,
  output logic [NREG-1:0]              busy_o,
  output logic [$clog2(LONG_MAX+1)-1:0] long_cnt_o
);

  localparam int LC_W = $clog2(LONG_MAX + 1);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [LC_W-1:0]  long_cnt_q, long_cnt_d;

  wb_req_t          wba, wbb;
  logic             thr, hz, issue, wbb_ready;
  logic             rf_we;
  logic [REG_W-1:0] rf_rd;
  logic [XLEN-1:0]  rf_wdata;
  logic             long_inc, long_dec;

  assign wba = '{valid: bus.wba_valid, rd: bus.wba_rd, data: bus.wba_data};
  assign wbb = '{valid: bus.wbb_valid, rd: bus.wbb_rd, data: bus.wbb_data};

  wb_arbiter #(
    .STARVE_LIM (STARVE_LIM)
  ) u_arb (
    .clk         (clk),
    .clr         (clr),
    .wba_i       (wba),
    .wbb_i       (wbb),
    .wbb_ready_o (wbb_ready),
    .rf_we_o     (rf_we),
    .rf_rd_o     (rf_rd),
    .rf_wdata_o  (rf_wdata),
    .thr_o       (thr)
  );

  // WAW on a busy rd also stalls so a short write can never overtake a
  // pending long write to the same register.
  always_comb begin
    hz = (bus.id_use_rs1 && reg_nz(bus.id_rs1) && busy_q[bus.id_rs1]) ||
         (bus.id_use_rs2 && reg_nz(bus.id_rs2) && busy_q[bus.id_rs2]) ||
         (bus.id_wr      && reg_nz(bus.id_rd)  && busy_q[bus.id_rd])  ||
         (bus.id_wr && bus.id_long && (long_cnt_q == LC_W'(LONG_MAX)));
  end

  // An instruction present during reset is dropped rather than issued.
  assign issue = bus.id_valid && !hz && !thr && bus.ex_ready && !clr;

  assign bus.issue     = issue;
  assign bus.stall     = bus.id_valid && (hz || thr);
  assign bus.wbb_ready = wbb_ready;
  assign bus.rf_we     = rf_we;
  assign bus.rf_rd     = rf_rd;
  assign bus.rf_wdata  = rf_wdata;

  // Clear first, then set: a same-cycle set of the register being written wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we)
      busy_d[rf_rd] = 1'b0;
    if (issue && bus.id_wr && reg_nz(bus.id_rd))
      busy_d[bus.id_rd] = 1'b1;
  end

  assign long_inc = issue && bus.id_wr && bus.id_long;
  assign long_dec = bus.wbb_valid && wbb_ready;

  always_comb begin
    long_cnt_d = long_cnt_q;
    if (long_inc && !long_dec)
      long_cnt_d = long_cnt_q + LC_W'(1);
    else if (long_dec && !long_inc && (long_cnt_q != '0))
      long_cnt_d = long_cnt_q - LC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      busy_q     <= '0;
      long_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      long_cnt_q <= long_cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign long_cnt_o = long_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] busy;
  logic [2:0]  long_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  exp_t exp_q[$];

  reg_scoreboard_if bus ();

  reg_scoreboard #(
    .LONG_MAX   (4),
    .STARVE_LIM (6)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus),
    .busy_o     (busy),
    .long_cnt_o (long_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write is matched against the queue of writes the
  // stimulus expects, in order.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        fail_cnt++;
        $error("FAIL rf_unexpected: observed write x%0d data 0x%0h expected no write",
               bus.rf_rd, bus.rf_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_rf_rd", 32'(bus.rf_rd), 32'(e.rd));
        chk("sb_rf_wdata", bus.rf_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.wba_valid = 1'b0;
    bus.wbb_valid = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic lng);
    bus.id_valid   = v;
    bus.id_rs1     = rs1;
    bus.id_use_rs1 = u1;
    bus.id_rs2     = rs2;
    bus.id_use_rs2 = u2;
    bus.id_rd      = rd;
    bus.id_wr      = wr;
    bus.id_long    = lng;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Drives both writeback ports for one cycle and records the write the
  // register file must see: ALU first, long unit only when the ALU is idle,
  // nothing for x0.
  task automatic set_wb(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    bus.wba_valid = av;
    bus.wba_rd    = ard;
    bus.wba_data  = ad;
    bus.wbb_valid = bv;
    bus.wbb_rd    = brd;
    bus.wbb_data  = bd;
    if (av) begin
      if (ard != 5'd0) exp_q.push_back('{rd: ard, data: ad});
    end else if (bv) begin
      if (brd != 5'd0) exp_q.push_back('{rd: brd, data: bd});
    end
  endtask

  initial begin
    clr          = 1'b1;
    bus.ex_ready = 1'b1;
    idle();
    set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    clr = 1'b0;
    settle();
    chk("reset_busy", busy, 32'd0);
    chk("reset_long_cnt", 32'(long_cnt), 32'd0);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset_wbb_ready", 32'(bus.wbb_ready), 32'd1);

    // RAW on an ALU result: x5 <- short, then x1 = x5 + x0.
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    settle();
    chk("raw_issue_x5", 32'(bus.issue), 32'd1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    settle();
    chk("raw_busy5_set", 32'(busy[5]), 32'd1);
    chk("raw_stall_c1", 32'(bus.stall), 32'd1);
    chk("raw_noissue_c1", 32'(bus.issue), 32'd0);
    tick();
    set_wb(1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 32'd0);
    settle();
    chk("raw_stall_wb_cycle", 32'(bus.stall), 32'd1);
    chk("raw_rf_rd5", 32'(bus.rf_rd), 32'd5);
    tick();
    settle();
    chk("raw_stall_after_wb", 32'(bus.stall), 32'd0);
    chk("raw_issue_after_wb", 32'(bus.issue), 32'd1);
    chk("raw_busy5_clear", 32'(busy[5]), 32'd0);
    tick();
    idle();
    set_wb(1'b1, 5'd1, 32'h0000_1111, 1'b0, 5'd0, 32'd0);
    tick();
    settle();
    chk("raw_busy_drained", busy, 32'd0);

    // Long WAW on x7.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    settle();
    chk("waw_issue_long", 32'(bus.issue), 32'd1);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    settle();
    chk("waw_long_cnt1", 32'(long_cnt), 32'd1);
    chk("waw_stall_c1", 32'(bus.stall), 32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    settle();
    chk("waw_stall_wb_cycle", 32'(bus.stall), 32'd1);
    chk("waw_wbb_ready", 32'(bus.wbb_ready), 32'd1);
    chk("waw_rf_rd7", 32'(bus.rf_rd), 32'd7);
    chk("waw_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    tick();
    settle();
    chk("waw_issue_short", 32'(bus.issue), 32'd1);
    chk("waw_long_cnt0", 32'(long_cnt), 32'd0);
    tick();
    idle();
    set_wb(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 32'd0);
    tick();
    settle();
    chk("waw_busy_drained", busy, 32'd0);

    // Port collision.
    set_wb(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    settle();
    chk("col_rf_rd3", 32'(bus.rf_rd), 32'd3);
    chk("col_wbb_ready0", 32'(bus.wbb_ready), 32'd0);
    tick();
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22);
    settle();
    chk("col_rf_rd4", 32'(bus.rf_rd), 32'd4);
    chk("col_wbb_ready1", 32'(bus.wbb_ready), 32'd1);
    tick();
    settle();
    chk("col_busy_unchanged", busy, 32'd0);
    chk("col_long_cnt_floor", 32'(long_cnt), 32'd0);

    // Starvation: ALU and long unit both valid for six cycles.
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      set_wb(1'b1, 5'd2, 32'(i), 1'b1, 5'd6, 32'h66);
      settle();
      chk("starve_no_stall", 32'(bus.stall), 32'd0);
      tick();
    end
    set_wb(1'b1, 5'd2, 32'h0000_0006, 1'b1, 5'd6, 32'h66);
    settle();
    chk("starve_stall_c6", 32'(bus.stall), 32'd1);
    chk("starve_noissue_c6", 32'(bus.issue), 32'd0);
    tick();
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
    settle();
    chk("starve_stall_accept", 32'(bus.stall), 32'd1);
    chk("starve_rf_rd6", 32'(bus.rf_rd), 32'd6);
    tick();
    settle();
    chk("starve_stall_drop", 32'(bus.stall), 32'd0);
    chk("starve_issue_resume", 32'(bus.issue), 32'd1);
    idle();

    // Long limit: four long ops to x8..x11, a fifth to x12 must wait.
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(8 + i), 1'b1, 1'b1);
      settle();
      chk("lim_issue", 32'(bus.issue), 32'd1);
      tick();
    end
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    settle();
    chk("lim_long_cnt4", 32'(long_cnt), 32'd4);
    chk("lim_busy_8_11", busy, 32'h0000_0F00);
    chk("lim_stall_fifth", 32'(bus.stall), 32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
    settle();
    chk("lim_stall_accept", 32'(bus.stall), 32'd1);
    tick();
    settle();
    chk("lim_long_cnt3", 32'(long_cnt), 32'd3);
    chk("lim_fifth_issue", 32'(bus.issue), 32'd1);
    tick();
    idle();
    settle();
    chk("lim_long_cnt_back4", 32'(long_cnt), 32'd4);
    for (int i = 9; i <= 12; i++) begin
      set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i));
      tick();
    end
    settle();
    chk("lim_long_cnt_drained", 32'(long_cnt), 32'd0);
    chk("lim_busy_drained", busy, 32'd0);

    // x0: writes are suppressed, readers never stall.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    set_wb(1'b1, 5'd0, 32'h0000_00FF, 1'b1, 5'd0, 32'h0000_00EE);
    settle();
    chk("x0_rf_we", 32'(bus.rf_we), 32'd0);
    chk("x0_wbb_ready", 32'(bus.wbb_ready), 32'd0);
    chk("x0_issue", 32'(bus.issue), 32'd1);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("x0_busy_none", busy, 32'd0);
    chk("x0_reader_stall", 32'(bus.stall), 32'd0);
    tick();

    // Reset with x9 busy.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    settle();
    chk("rst_issue_x9", 32'(bus.issue), 32'd1);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    clr = 1'b1;
    settle();
    chk("rst_busy9_before", 32'(busy[9]), 32'd1);
    tick();
    clr = 1'b0;
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("rst_busy_cleared", busy, 32'd0);
    chk("rst_reader_stall", 32'(bus.stall), 32'd0);
    chk("rst_reader_issue", 32'(bus.issue), 32'd1);
    tick();
    idle();
    set_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    settle();
    chk("rst_inflight_we", 32'(bus.rf_we), 32'd1);
    tick();
    settle();
    chk("rst_inflight_busy", busy, 32'd0);
    chk("rst_inflight_long", 32'(long_cnt), 32'd0);

    tick();
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
